// File: rtl/prochot_src_pkg.sv
// Shared types and source indices for the PROCHOT# source conditioning block.
// PROCHOT_SRC_FILTER_BYPASS_EN is interpreted in prochot_src_qual.
package prochot_src_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    ACTIVE  = 2'd2,
    STRETCH = 2'd3
  } src_state_e;

  localparam int NUM_SRC      = 3;
  localparam int SRC_VRHOT    = 0;
  localparam int SRC_PWRALERT = 1;
  localparam int SRC_THROTTLE = 2;

  // Event summation needs to know how many sources fired in one cycle.
  function automatic logic [1:0] count_evts(input logic [NUM_SRC-1:0] evt);
    logic [1:0] sum;
    sum = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = sum + {1'b0, evt[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/prochot_src_qual.sv
// One throttle source: 2-flop resync, glitch qualifier and minimum-assert stretcher.
// Define PROCHOT_SRC_FILTER_BYPASS_EN to replace qualify/stretch with a plain registered follower.
module prochot_src_qual
  import prochot_src_pkg::*;
#(
  parameter int FILT_CYC    = 4,
  parameter int STRETCH_CYC = 200
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iPwrgd,
  input  logic iAct,
  output logic oAct,
  output logic oEvt
);

  logic [1:0] sync_reg;
  logic       act_sync;
  logic       act_reg;

  // Syncs are flushed while PWROK is low so a held source requalifies from scratch.
  always_ff @(posedge iClk) begin
    if (!iRst_n || !iPwrgd) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], iAct};
    end
  end

  assign act_sync = sync_reg[1];

`ifdef PROCHOT_SRC_FILTER_BYPASS_EN

  logic evt_next;

  always_comb begin
    evt_next = act_sync & ~act_reg & iPwrgd;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      act_reg <= 1'b0;
    end else begin
      act_reg <= act_sync & iPwrgd;
    end
  end

  assign oEvt = evt_next;

`else

  localparam logic [7:0]  QUAL_LAST = 8'(FILT_CYC - 1);
  localparam logic [15:0] HOLD_MAX  = 16'(STRETCH_CYC);

  src_state_e  state_reg,    state_next;
  logic [7:0]  qual_cnt_reg, qual_cnt_next;
  logic [15:0] hold_cnt_reg, hold_cnt_next;
  logic [15:0] hold_inc;
  logic        hold_done;
  logic        evt_next;
  logic        act_next;

  always_comb begin
    hold_inc  = (hold_cnt_reg >= HOLD_MAX) ? HOLD_MAX : hold_cnt_reg + 16'd1;
    hold_done = (hold_cnt_reg >= HOLD_MAX);
  end

  always_comb begin
    state_next    = state_reg;
    qual_cnt_next = qual_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    evt_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (act_sync) begin
          if (FILT_CYC == 1) begin
            state_next    = ACTIVE;
            hold_cnt_next = 16'd0;
            evt_next      = 1'b1;
          end else begin
            state_next    = QUAL;
            qual_cnt_next = 8'd1;
          end
        end
      end
      QUAL: begin
        if (!act_sync) begin
          state_next = IDLE;
        end else if (qual_cnt_reg == QUAL_LAST) begin
          state_next    = ACTIVE;
          hold_cnt_next = 16'd0;
          evt_next      = 1'b1;
        end else begin
          qual_cnt_next = qual_cnt_reg + 8'd1;
        end
      end
      ACTIVE: begin
        hold_cnt_next = hold_inc;
        if (!act_sync) begin
          state_next = hold_done ? IDLE : STRETCH;
        end
      end
      STRETCH: begin
        hold_cnt_next = hold_inc;
        // Re-assertion during stretch resumes the same event; hold keeps running.
        if (act_sync) begin
          state_next = ACTIVE;
        end else if (hold_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (!iPwrgd) begin
      state_next = IDLE;
      evt_next   = 1'b0;
    end
    act_next = (state_next == ACTIVE) || (state_next == STRETCH);
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_reg    <= IDLE;
      qual_cnt_reg <= 8'd0;
      hold_cnt_reg <= 16'd0;
      act_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      qual_cnt_reg <= qual_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      act_reg      <= act_next;
    end
  end

  assign oEvt = evt_next;

`endif

  assign oAct = act_reg;

endmodule

// File: rtl/prochot_src_cond.sv
// Conditions VRHOT#, PWR_IN_ALERT# and SYS_THROTTLE for the PROCHOT# driver; sticky status and event count for BMC.
// PROCHOT_SRC_FILTER_BYPASS_EN (see prochot_src_qual) drops qualification and stretching.
module prochot_src_cond
  import prochot_src_pkg::*;
#(
  parameter int FILT_CYC    = 4,
  parameter int STRETCH_CYC = 200,
  parameter int CNT_W       = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iPwrgdSysPwrok,
  input  logic             iVrhotN,
  input  logic             iPwrInAlertN,
  input  logic             iSysThrottle,
  input  logic             iStatusClr,
  output logic             oVrhotN,
  output logic             oPwrInAlertN,
  output logic             oSysThrottle,
  output logic [2:0]       oStickyStatus,
  output logic [CNT_W-1:0] oEvtCnt
);

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [NUM_SRC-1:0] act_raw;
  logic [NUM_SRC-1:0] act_q;
  logic [NUM_SRC-1:0] evt;

  logic [2:0]       sticky_reg, sticky_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W+1:0] cnt_sum;

  // Everything downstream works in active-high.
  assign act_raw[SRC_VRHOT]    = ~iVrhotN;
  assign act_raw[SRC_PWRALERT] = ~iPwrInAlertN;
  assign act_raw[SRC_THROTTLE] = iSysThrottle;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      prochot_src_qual #(
        .FILT_CYC    (FILT_CYC),
        .STRETCH_CYC (STRETCH_CYC)
      ) u_qual (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iPwrgd (iPwrgdSysPwrok),
        .iAct   (act_raw[gi]),
        .oAct   (act_q[gi]),
        .oEvt   (evt[gi])
      );
    end
  endgenerate

  // Clear is applied before the same-cycle events are folded in.
  always_comb begin
    cnt_base    = iStatusClr ? '0 : cnt_reg;
    sticky_next = (iStatusClr ? 3'b000 : sticky_reg) | evt;
    cnt_sum     = (CNT_W+2)'(cnt_base) + (CNT_W+2)'(count_evts(evt));
    cnt_next    = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sticky_reg <= 3'b000;
      cnt_reg    <= '0;
    end else begin
      sticky_reg <= sticky_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign oVrhotN       = ~act_q[SRC_VRHOT];
  assign oPwrInAlertN  = ~act_q[SRC_PWRALERT];
  assign oSysThrottle  = act_q[SRC_THROTTLE];
  assign oStickyStatus = sticky_reg;
  assign oEvtCnt       = cnt_reg;

endmodule

// File: tb/tb_prochot_src_cond.sv
// Scoreboard bench for prochot_src_cond: stimulus queues expected values tagged with a cycle, monitor compares.
module tb_prochot_src_cond;

  logic       clk = 1'b0;
  logic       rst_n, pwrok, vrhot_n, alert_n, thr, clr;
  logic       o_vrhot_n, o_alert_n, o_thr;
  logic [2:0] sticky;
  logic [7:0] cnt;

  always #5 clk = ~clk;

  prochot_src_cond #(
    .FILT_CYC    (4),
    .STRETCH_CYC (200),
    .CNT_W       (8)
  ) dut (
    .iClk           (clk),
    .iRst_n         (rst_n),
    .iPwrgdSysPwrok (pwrok),
    .iVrhotN        (vrhot_n),
    .iPwrInAlertN   (alert_n),
    .iSysThrottle   (thr),
    .iStatusClr     (clr),
    .oVrhotN        (o_vrhot_n),
    .oPwrInAlertN   (o_alert_n),
    .oSysThrottle   (o_thr),
    .oStickyStatus  (sticky),
    .oEvtCnt        (cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic push(input int dc, input int kind, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.kind = kind;
    e.val  = v;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // outs = {oSysThrottle, oPwrInAlertN, oVrhotN}
  task automatic expect_all(input int dc, input logic [2:0] outs, input logic [2:0] st,
                            input logic [7:0] c, input string nm);
    push(dc, 0, {5'b0, outs}, {nm, ".out"});
    push(dc, 1, {5'b0, st},   {nm, ".sticky"});
    push(dc, 2, c,            {nm, ".cnt"});
  endtask

  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].kind)
          0:       act = {5'b0, o_thr, o_alert_n, o_vrhot_n};
          1:       act = {5'b0, sticky};
          default: act = cnt;
        endcase
        n_chk++;
        if (sb[i].cyc < cyc) begin
          $display("FAIL %s cyc=%0d: check missed its cycle %0d", sb[i].nm, cyc, sb[i].cyc);
        end else if (act !== sb[i].val) begin
          $display("FAIL %s cyc=%0d: got %0h expected %0h", sb[i].nm, cyc, act, sb[i].val);
        end else begin
          n_pass++;
          $display("check %s cyc=%0d: value %0h ok", sb[i].nm, cyc, act);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    int m;
    rst_n = 1'b0; pwrok = 1'b1; vrhot_n = 1'b1; alert_n = 1'b1; thr = 1'b0; clr = 1'b0;
    step(2);
    expect_all(0, 3'b011, 3'b000, 8'd0, "reset");
    step(1);
    rst_n = 1'b1;
    step(3);

    // 3-cycle glitch is rejected
    vrhot_n = 1'b0;
    expect_all(6,  3'b011, 3'b000, 8'd0, "glitch6");
    expect_all(10, 3'b011, 3'b000, 8'd0, "glitch10");
    step(3);
    vrhot_n = 1'b1;
    step(12);

    // 50-cycle assertion, stretched to 201 cycles, with a short re-assert inside stretch
    vrhot_n = 1'b0;
    expect_all(5,   3'b011, 3'b000, 8'd0, "vr_pre");
    expect_all(6,   3'b010, 3'b001, 8'd1, "vr_assert");
    expect_all(104, 3'b010, 3'b001, 8'd1, "vr_reassert");
    expect_all(150, 3'b010, 3'b001, 8'd1, "vr_stretch");
    expect_all(206, 3'b010, 3'b001, 8'd1, "vr_last");
    expect_all(207, 3'b011, 3'b001, 8'd1, "vr_release");
    step(50);
    vrhot_n = 1'b1;
    step(50);
    vrhot_n = 1'b0;
    step(2);
    vrhot_n = 1'b1;
    step(110);

    // all three together, status clear on the qualifying edge
    vrhot_n = 1'b0; alert_n = 1'b0; thr = 1'b1;
    expect_all(5,   3'b011, 3'b001, 8'd1, "all_pre");
    expect_all(6,   3'b100, 3'b111, 8'd3, "all_clr");
    expect_all(210, 3'b111, 3'b111, 8'd3, "thr_only");
    step(5);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(14);
    vrhot_n = 1'b1; alert_n = 1'b1;
    step(200);

    // PWROK drop/restore with throttle held
    pwrok = 1'b0;
    expect_all(1, 3'b011, 3'b111, 8'd3, "pwrok_drop");
    step(5);
    pwrok = 1'b1;
    expect_all(5, 3'b011, 3'b111, 8'd3, "pwrok_requal");
    expect_all(6, 3'b111, 3'b111, 8'd4, "pwrok_reassert");
    step(10);
    thr = 1'b0;
    step(230);

    // standalone clear
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    expect_all(0, 3'b011, 3'b000, 8'd0, "clear");
    step(3);

    // 100 triple pulses = 300 events, saturating at 255
    m = 0;
    for (int p = 0; p < 100; p++) begin
      m = (m + 3 > 255) ? 255 : m + 3;
      push(6, 2, 8'(m), $sformatf("sat%0d.cnt", p));
      vrhot_n = 1'b0; alert_n = 1'b0; thr = 1'b1;
      step(6);
      vrhot_n = 1'b1; alert_n = 1'b1; thr = 1'b0;
      step(209);
    end
    expect_all(0, 3'b011, 3'b111, 8'd255, "saturated");
    step(2);

    // reset during qualification
    vrhot_n = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(1);
    expect_all(0, 3'b011, 3'b000, 8'd0, "rst_midqual");
    vrhot_n = 1'b1;
    step(1);
    rst_n = 1'b1;
    expect_all(8, 3'b011, 3'b000, 8'd0, "post_rst");
    step(12);

    foreach (sb[i]) begin
      n_chk++;
      $display("FAIL %s: never checked (due cyc %0d)", sb[i].nm, sb[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prochot_src_cond.md
Name: prochot_src_cond

Overview:
- Input conditioning stage directly upstream of the PROCHOT# driver in the core CPLD.
- Takes the three raw forced-throttle sources (CPU VR VRHOT#, PVCCIN power-in alert, ME SYS_THROTTLE) and resynchronises, glitch-filters and minimum-stretches each one.
- Delivers clean qualified levels to the PROCHOT# driver.
- Keeps sticky per-source status and a saturating throttle-event counter for BMC readout.

Parameters:
- FILT_CYC, 4, consecutive synchronised active samples needed to qualify an assertion (2 us at 2 MHz); legal range 1..255.
- STRETCH_CYC, 200, minimum qualified-assert duration in iClk cycles, counted from entry into ACTIVE; legal range 1..65535.
- CNT_W, 8, event counter width.

Ports:
- iClk  in  1  2 MHz clock.
- iRst_n  in  1  reset, synchronous, active-low.
- iPwrgdSysPwrok  in  1  system PWROK; low forces all sources inactive.
- iVrhotN  in  1  raw IRQ_PVCCIN_VRHOT#, async, active-low.
- iPwrInAlertN  in  1  raw FM_PVCCIN_PWR_IN_ALERT#, async, active-low.
- iSysThrottle  in  1  raw FM_SYS_THROTTLE, async, active-high.
- iStatusClr  in  1  single-cycle pulse; clears sticky status and counter.
- oVrhotN  out  1  qualified VRHOT#, active-low.
- oPwrInAlertN  out  1  qualified power alert, active-low.
- oSysThrottle  out  1  qualified throttle, active-high.
- oStickyStatus  out  3  bit0 VRHOT, bit1 PWR_IN_ALERT, bit2 SYS_THROTTLE; 1 = has qualified since last clear.
- oEvtCnt  out  CNT_W  number of IDLE->ACTIVE entries across all sources, saturating.

Behaviour:
- Reset (iRst_n low at a rising edge):
  - oVrhotN=1, oPwrInAlertN=1, oSysThrottle=0, oStickyStatus=0, oEvtCnt=0.
  - Sync flops are loaded with the inactive level; all FSMs go to IDLE; counters are cleared.
- Internal polarity: each input is converted to an active-high "act" before a 2-flop synchroniser. All outputs are registered.
- Per-source FSM has four states: IDLE, QUAL, ACTIVE, STRETCH.
  - IDLE: output inactive. If act_sync=1, load qual counter=1 and go to QUAL. If FILT_CYC=1, go directly to ACTIVE.
  - QUAL: if act_sync=0, go to IDLE (glitch rejected). If act_sync=1 and qual counter=FILT_CYC-1, go to ACTIVE. Otherwise increment the qual counter.
  - ACTIVE: output active. A hold counter, cleared on entry, increments and saturates at STRETCH_CYC. If act_sync=0: go to IDLE when hold counter >= STRETCH_CYC, else go to STRETCH.
  - STRETCH: output stays active and the hold counter keeps counting. If act_sync=1, return to ACTIVE without resetting the hold counter and without counting a new event. When hold counter reaches STRETCH_CYC, go to IDLE.
- Latency:
  - Assertion: output changes on the (FILT_CYC+2)th rising edge after the first edge that samples the raw input active.
  - Deassertion: output changes 3 edges after the raw input clears, or at stretch expiry, whichever is later.
- PWROK gating: while iPwrgdSysPwrok=0, all FSMs are held in IDLE and outputs are inactive. Sticky status and oEvtCnt are retained. When PWROK rises, a source that is already active must requalify for a full FILT_CYC.
- Events:
  - Each IDLE/QUAL->ACTIVE transition sets the corresponding sticky bit and adds 1 to oEvtCnt.
  - Simultaneous transitions add their count (up to 3) in one cycle. oEvtCnt saturates at 2^CNT_W-1 and never wraps.
- iStatusClr coinciding with an event: the clear applies first, then the event. The sticky bit is set and oEvtCnt equals the number of events in that cycle.
- Reset mid-qualification or mid-stretch returns the block to the reset state on the same edge; no event is counted.

Optional Feature:
- Macro: PROCHOT_SRC_FILTER_BYPASS_EN.
- Defined:
  - QUAL and STRETCH are removed; each output follows act_sync through one register, for a latency of 3 edges.
  - Events are counted on rising edges of act_sync; PWROK gating is unchanged.
- Undefined: full FSM behaviour as described above.

Decomposition:
- Package prochot_src_pkg holds:
  - the state enum {IDLE, QUAL, ACTIVE, STRETCH};
  - NUM_SRC=3;
  - source indices SRC_VRHOT=0, SRC_PWRALERT=1, SRC_THROTTLE=2.
- Sub-module prochot_src_qual contains the synchroniser, FSM and counters. It is instantiated three times and outputs an active-high level plus a one-cycle event pulse.
- Top level handles polarity conversion, sticky status, event summation and saturation.

Test Plan:
- FILT_CYC=4: iVrhotN low for 3 cycles -> oVrhotN stays 1, oEvtCnt=0, oStickyStatus=0.
- iVrhotN low for 50 cycles -> oVrhotN=0 at edge 6; it stays 0 until hold counter=200 and returns to 1 ~201 cycles after entry; oEvtCnt=1, oStickyStatus=3'b001.
- Within STRETCH, iVrhotN re-asserted for 2 cycles -> no deassert pulse, oEvtCnt stays 1.
- All three sources asserted on the same edge -> all outputs active on the same edge, oEvtCnt=3, sticky=3'b111; iStatusClr on that edge -> oEvtCnt=3.
- iPwrgdSysPwrok dropped while oSysThrottle=1 -> oSysThrottle=0 next edge, oEvtCnt unchanged; PWROK restored with input held -> reassert after FILT_CYC+2, oEvtCnt+1.
- 300 qualified pulses -> oEvtCnt saturates at 255; iRst_n low mid-QUAL -> all outputs at reset values next edge.
